// File: rtl/gpio_cnt_sched_pkg.sv
// gpio_cnt_sched_pkg: shared types and constants for the GPIO counter scheduler
package gpio_cnt_sched_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} fsm_state;
  localparam fsm_state StateDefault = IDLE;
  localparam int MaxCh = 16;
  localparam int CntMaxDefault = 2048;
endpackage

// File: rtl/gpio_cnt_rr_arb.sv
// gpio_cnt_rr_arb: combinational round-robin picker, first request at or after ptr (wrapping)
module gpio_cnt_rr_arb #(
  parameter int NumCh = 4,
  parameter int IdxW = $clog2(NumCh)
) (
  input  logic [NumCh-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic [NumCh-1:0] gnt,
  output logic [IdxW-1:0]  idx,
  output logic             valid
);
  logic [IdxW:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    valid = |req;
    // scan farthest-first so the channel closest to ptr overwrites last and wins
    for (int i = NumCh - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (IdxW + 1)'(i);
      j = (j >= (IdxW + 1)'(NumCh)) ? j - (IdxW + 1)'(NumCh) : j;
      if (req[j[IdxW-1:0]]) begin
        gnt = '0;
        gnt[j[IdxW-1:0]] = 1'b1;
        idx = j[IdxW-1:0];
      end
    end
  end
endmodule

// File: rtl/gpio_cnt_sched.sv
// gpio_cnt_sched: one threshold counter shared round-robin among GPIO request lines.
// Define GPIO_CNT_SCHED_IRQ_EN to add the intr_o completion pulse.
module gpio_cnt_sched
  import gpio_cnt_sched_pkg::*;
#(
  parameter int NumCh = 4,
  parameter int CntWidth = 32,
  parameter int CntMaxRst = CntMaxDefault
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumCh-1:0]    gpio_i,
  input  logic [CntWidth-1:0] cnt_max_i,
`ifdef GPIO_CNT_SCHED_IRQ_EN
  output logic                intr_o,
`endif
  output logic [NumCh-1:0]    gpio_o,
  output logic [NumCh-1:0]    grant_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] cnt_o
);
  localparam int IdxW = $clog2(NumCh);
  fsm_state state, state_n;
  logic [IdxW-1:0] ptr, ptr_n, arb_idx;
  logic [NumCh-1:0] arb_gnt, grant_n, done_set, gpio_n;
  logic arb_valid;
  logic [CntWidth-1:0] cnt, cnt_n, thr, thr_n;
  gpio_cnt_rr_arb #(.NumCh(NumCh), .IdxW(IdxW)) u_arb (
    .req   (gpio_i & ~gpio_o),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = grant_o;
    cnt_n = cnt;
    thr_n = thr;
    done_set = '0;
    case (state)
      IDLE: if (arb_valid) begin
        state_n = COUNT;
        grant_n = arb_gnt;
        cnt_n = '0;
        thr_n = (cnt_max_i == '0) ? CntWidth'(CntMaxRst) : cnt_max_i;
        ptr_n = (arb_idx == IdxW'(NumCh - 1)) ? '0 : arb_idx + 1'b1;
      end
      // a dropped request aborts even on the completion cycle
      COUNT: if (~|(gpio_i & grant_o)) begin
        state_n = IDLE;
        cnt_n = '0;
        grant_n = '0;
      end else if (cnt == thr) begin
        done_set = grant_o;
        state_n = IDLE;
        cnt_n = '0;
        grant_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: begin
        state_n = StateDefault;
        cnt_n = '0;
        grant_n = '0;
      end
    endcase
  end
  assign gpio_n = (gpio_o & gpio_i) | done_set;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      grant_o <= '0;
      cnt <= '0;
      thr <= '0;
      gpio_o <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_o <= grant_n;
      cnt <= cnt_n;
      thr <= thr_n;
      gpio_o <= gpio_n;
    end
  end
`ifdef GPIO_CNT_SCHED_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) intr_o <= 1'b0;
    else intr_o <= |done_set;
  end
`endif
  assign busy_o = (state == COUNT);
  assign cnt_o = cnt;
endmodule

// File: tb/tb_gpio_cnt_sched.sv
// tb_gpio_cnt_sched: directed self-checking bench for gpio_cnt_sched
module tb_gpio_cnt_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] gpio = '0;
  logic [31:0] cnt_max = '0;
  logic [3:0] gpio_o, grant;
  logic busy;
  logic [31:0] cnt;
  logic intr = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_cnt_sched #(.NumCh(4), .CntWidth(32), .CntMaxRst(2048)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .gpio_i    (gpio),
    .cnt_max_i (cnt_max),
`ifdef GPIO_CNT_SCHED_IRQ_EN
    .intr_o    (intr),
`endif
    .gpio_o    (gpio_o),
    .grant_o   (grant),
    .busy_o    (busy),
    .cnt_o     (cnt)
  );

  task automatic do_reset;
    @(negedge clk);
    gpio = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if (gpio_o !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || cnt !== 32'd0 || intr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values gpio_o=%b grant=%b busy=%b cnt=%0d intr=%b, want all zero", gpio_o, grant, busy, cnt, intr);
    end
  endtask

  task automatic test_basic;
    do_reset;
    cnt_max = 32'd5;
    gpio = 4'b0100;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (grant !== 4'b0100 || busy !== 1'b1 || cnt !== 32'(k) || gpio_o !== 4'b0 || intr !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_count k=%0d grant=%b busy=%b cnt=%0d gpio_o=%b intr=%b, want 0100 1 %0d 0000 0", k, grant, busy, cnt, gpio_o, intr, k);
      end
    end
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0100 || grant !== 4'b0 || busy !== 1'b0 || cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL basic_done gpio_o=%b grant=%b busy=%b cnt=%0d, want 0100 0000 0 0", gpio_o, grant, busy, cnt);
    end
`ifdef GPIO_CNT_SCHED_IRQ_EN
    n_tests++;
    if (intr !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_intr_pulse intr=%b, want 1", intr);
    end
`endif
    gpio = '0;
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0 || intr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release gpio_o=%b intr=%b busy=%b, want 0000 0 0", gpio_o, intr, busy);
    end
  endtask

  task automatic test_round_robin;
    int chs[3] = '{0, 1, 3};
    logic [3:0] exp_o, g;
    do_reset;
    cnt_max = 32'd3;
    gpio = 4'b1011;
    exp_o = '0;
    for (int n = 0; n < 3; n++) begin
      g = '0;
      g[chs[n]] = 1'b1;
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        n_tests++;
        if (grant !== g || busy !== 1'b1 || cnt !== 32'(k) || gpio_o !== exp_o) begin
          n_fail++;
          $display("FAIL rr_count ch=%0d k=%0d grant=%b busy=%b cnt=%0d gpio_o=%b, want %b 1 %0d %b", chs[n], k, grant, busy, cnt, gpio_o, g, k, exp_o);
        end
      end
      exp_o[chs[n]] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (gpio_o !== exp_o || grant !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_done ch=%0d gpio_o=%b grant=%b busy=%b, want %b 0000 0", chs[n], gpio_o, grant, busy, exp_o);
      end
    end
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b1011 || grant !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle gpio_o=%b grant=%b busy=%b, want 1011 0000 0", gpio_o, grant, busy);
    end
  endtask

  task automatic test_abort;
    do_reset;
    cnt_max = 32'd100;
    gpio = 4'b0010;
    repeat (20) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || cnt !== 32'd19 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL abort_pre busy=%b cnt=%0d grant=%b, want 1 19 0010", busy, cnt, grant);
    end
    gpio = '0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || grant !== 4'b0 || cnt !== 32'd0 || gpio_o !== 4'b0 || intr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_exit busy=%b grant=%b cnt=%0d gpio_o=%b intr=%b, want 0 0000 0 0000 0", busy, grant, cnt, gpio_o, intr);
    end
    gpio = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || grant !== 4'b0010 || cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL abort_restart busy=%b grant=%b cnt=%0d, want 1 0010 1", busy, grant, cnt);
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    cnt_max = 32'd2;
    gpio = 4'b0001;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cnt !== 32'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_pre cnt=%0d busy=%b, want 2 1", cnt, busy);
    end
    gpio = '0;
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0 || busy !== 1'b0 || grant !== 4'b0 || intr !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_abort_wins gpio_o=%b busy=%b grant=%b intr=%b, want 0000 0 0000 0", gpio_o, busy, grant, intr);
    end
  endtask

  task automatic test_threshold;
    do_reset;
    cnt_max = 32'd4;
    gpio = 4'b0100;
    @(negedge clk);
    cnt_max = 32'd50;
    repeat (4) @(negedge clk);
    n_tests++;
    if (cnt !== 32'd4 || gpio_o !== 4'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_latch_pre cnt=%0d gpio_o=%b busy=%b, want 4 0000 1", cnt, gpio_o, busy);
    end
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_latch_done gpio_o=%b busy=%b, want 0100 0", gpio_o, busy);
    end
    do_reset;
    cnt_max = 32'd0;
    gpio = 4'b0001;
    repeat (2049) @(negedge clk);
    n_tests++;
    if (cnt !== 32'd2048 || busy !== 1'b1 || gpio_o !== 4'b0) begin
      n_fail++;
      $display("FAIL thr_zero_pre cnt=%0d busy=%b gpio_o=%b, want 2048 1 0000", cnt, busy, gpio_o);
    end
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0001 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_zero_done gpio_o=%b busy=%b, want 0001 0", gpio_o, busy);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    cnt_max = 32'd1;
    gpio = 4'b0010;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if (gpio_o !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || cnt !== 32'd0 || intr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async gpio_o=%b grant=%b busy=%b cnt=%0d intr=%b, want all zero", gpio_o, grant, busy, cnt, intr);
    end
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done gpio_o=%b busy=%b, want 0000 0", gpio_o, busy);
    end
    rst_n = 1'b1;
    gpio = 4'b0110;
    @(negedge clk);
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_mid_ptr grant=%b, want 0010", grant);
    end
  endtask

  task automatic test_release;
    do_reset;
    cnt_max = 32'd3;
    gpio = 4'b1000;
    repeat (5) @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b1000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release_setup gpio_o=%b busy=%b, want 1000 0", gpio_o, busy);
    end
    gpio = 4'b1001;
    @(negedge clk);
    gpio = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (gpio_o !== 4'b0000 || busy !== 1'b1 || grant !== 4'b0001 || cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL release_during_count gpio_o=%b busy=%b grant=%b cnt=%0d, want 0000 1 0001 1", gpio_o, busy, grant, cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_abort;
    test_simultaneous;
    test_threshold;
    test_reset_mid;
    test_release;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
